pio_in_edge_irq: RTL

Parametrised Avalon-MM input PIO for the Nios subsystem. It supersedes the fixed 4-bit switch port. The block synchronises and debounces a WIDTH-bit input bus and captures edges per bit according to a programmable mode. When an enabled capture bit is set, it raises a level interrupt to the Nios IRQ controller. It is read with the same 1-cycle registered read latency as the existing PIO slaves.

---
 rtl/pio_in_edge_irq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: two-flop synchroniser, per-bit debounce, programmable
// edge capture (RW1C) and a masked level interrupt. Reads have 1-cycle latency.
module pio_in_edge_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_ANY  = 2'b10;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] stable, stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] rise, fall, det, clr;
  logic [WIDTH-1:0] irqmask, edgecap;
  logic [1:0]       mode;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  // Bus handshake: a write commits at the clock edge where chipselect & write
  // are both high. Reads carry no strobe; readdata always shows the register
  // selected by the address at the previous edge, with no side effects.
  assign wr_en = chipselect & write;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // A change on s2 must persist DEBOUNCE_CYCLES consecutive samples to reach stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable_d <= '0;
    else          stable_d <= stable;
  end

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  always_comb begin
    det = '0;
    case (mode)
      MODE_RISE: det = rise;
      MODE_FALL: det = fall;
      MODE_ANY:  det = rise | fall;
      default:   det = '0;
    endcase
  end

  assign clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident edge wins over the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode    <= MODE_RISE;
      irqmask <= '0;
      edgecap <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_MODE)    mode    <= writedata[1:0];
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      edgecap <= (edgecap & ~clr) | det;
      irq     <= |(edgecap & irqmask);
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      ADDR_MODE:    rd_next[1:0]       = mode;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:      rd_next            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule
